// File: rtl/led_scanner.sv
// led_scanner: PWM-dimmed LED bank with a moving head and a decaying tail.
// Bounce or wrap motion at fractional speed; exports head index and an end-of-sweep pulse.
module led_scanner #(
  parameter int NUM_LEDS    = 8,
  parameter int PWM_BITS    = 10,
  parameter int FRAC_BITS   = 8,
  parameter int STEP_W      = 8,
  parameter int PRESCALE    = 65536,
  parameter int DECAY_SHIFT = 2,
  localparam int IDX_W      = ($clog2(NUM_LEDS) < 1) ? 1 : $clog2(NUM_LEDS)
) (
  input  logic                clk_16mhz_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                mode_i,
  input  logic [STEP_W-1:0]   step_i,
  output logic [NUM_LEDS-1:0] led_o,
  output logic [IDX_W-1:0]    head_o,
  output logic                end_stop_o
);

  // dir state | meaning
  // DIR_UP    | head moving toward higher indices (always so in wrap mode)
  // DIR_DOWN  | head moving toward index 0 (bounce mode only)

  localparam int POS_W = IDX_W + FRAC_BITS;
  localparam int PS_W  = $clog2(PRESCALE);
  localparam logic [POS_W:0]      POS_MAX    = (POS_W+1)'((NUM_LEDS - 1) * (2 ** FRAC_BITS));
  localparam logic [POS_W:0]      POS_SPAN   = (POS_W+1)'(NUM_LEDS * (2 ** FRAC_BITS));
  localparam logic [PS_W-1:0]     PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  dir_e                dir_q, dir_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] bright_q [NUM_LEDS];
  logic [PWM_BITS-1:0] bright_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_d;
  logic                end_stop_d;
  logic                tick;
  logic [IDX_W-1:0]    head;
  logic [POS_W:0]      pos_ext, step_ext, sum;

  // Proportional decay, but never stalls above zero.
  function automatic logic [PWM_BITS-1:0] decay(input logic [PWM_BITS-1:0] b);
    logic [PWM_BITS-1:0] d;
    d = b >> DECAY_SHIFT;
    if (d == '0 && b != '0) d = PWM_BITS'(1);
    return b - d;
  endfunction

  assign head     = pos_q[POS_W-1:FRAC_BITS];
  assign head_o   = head;
  assign pos_ext  = {1'b0, pos_q};
  assign step_ext = (POS_W+1)'(step_i);
  assign sum      = pos_ext + step_ext;

  always_comb begin
    tick       = enable_i && (presc_q == PS_LAST);
    presc_d    = presc_q;
    pwm_d      = pwm_q + 1'b1;
    pos_d      = pos_q;
    dir_d      = dir_q;
    end_stop_d = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bright_d[i] = bright_q[i];
      led_d[i]    = enable_i && (pwm_q < bright_q[i]);
    end

    if (enable_i) presc_d = tick ? '0 : presc_q + 1'b1;

    if (tick) begin
      // Maximum goes to the pre-update head, so it trails head_o by one tick.
      for (int i = 0; i < NUM_LEDS; i++)
        bright_d[i] = (head == IDX_W'(i)) ? BRIGHT_MAX : decay(bright_q[i]);

      if (mode_i) begin
        dir_d = DIR_UP;
        if (sum >= POS_SPAN) begin
          pos_d      = POS_W'(sum - POS_SPAN);
          end_stop_d = 1'b1;
        end else begin
          pos_d = POS_W'(sum);
        end
      end else if (dir_q == DIR_UP) begin
        if (sum >= POS_MAX) begin
          pos_d      = POS_MAX[POS_W-1:0];
          dir_d      = DIR_DOWN;
          end_stop_d = 1'b1;
        end else begin
          pos_d = POS_W'(sum);
        end
      end else begin
        if (pos_ext <= step_ext) begin
          pos_d      = '0;
          dir_d      = DIR_UP;
          end_stop_d = 1'b1;
        end else begin
          pos_d = POS_W'(pos_ext - step_ext);
        end
      end
    end
  end

  always_ff @(posedge clk_16mhz_i or posedge rst_i) begin
    if (rst_i) begin
      dir_q      <= DIR_UP;
      pos_q      <= '0;
      presc_q    <= '0;
      pwm_q      <= '0;
      led_o      <= '0;
      end_stop_o <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) bright_q[i] <= '0;
    end else begin
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      presc_q    <= presc_d;
      pwm_q      <= pwm_d;
      led_o      <= led_d;
      end_stop_o <= end_stop_d;
      for (int i = 0; i < NUM_LEDS; i++) bright_q[i] <= bright_d[i];
    end
  end

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed phases plus randomized stimulus against an
// integer-arithmetic reference model of the scanner's motion, decay and PWM rules.
module tb_led_scanner;

  localparam int N     = 8;
  localparam int PWMB  = 10;
  localparam int FRAC  = 2;
  localparam int SW    = 5;
  localparam int PRE   = 4;
  localparam int DSH   = 2;
  localparam int MAXB  = (1 << PWMB) - 1;
  localparam int PMAX  = (N - 1) << FRAC;
  localparam int PSPAN = N << FRAC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          mode = 1'b0;
  logic [SW-1:0] step = 5'd4;
  logic [N-1:0]  led;
  logic [2:0]    head;
  logic          end_stop;

  led_scanner #(
    .NUM_LEDS(N), .PWM_BITS(PWMB), .FRAC_BITS(FRAC), .STEP_W(SW),
    .PRESCALE(PRE), .DECAY_SHIFT(DSH)
  ) dut (
    .clk_16mhz_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
    .step_i(step), .led_o(led), .head_o(head), .end_stop_o(end_stop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int es_count = 0;

  // reference model state
  int m_cnt, m_pos, m_dir, m_pwm, m_led, m_es;
  int m_bright [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pos = 0; m_dir = 0; m_pwm = 0; m_led = 0; m_es = 0;
    for (int i = 0; i < N; i++) m_bright[i] = 0;
  endtask

  task automatic model_step();
    int tick, h, s, n, d;
    int nb [N];
    if (rst) begin
      model_reset();
      return;
    end
    tick = (enable && m_cnt == PRE - 1) ? 1 : 0;
    m_led = 0;
    for (int i = 0; i < N; i++)
      if (enable && m_pwm < m_bright[i]) m_led |= (1 << i);
    m_es = 0;
    if (tick != 0) begin
      h = m_pos / (1 << FRAC);
      for (int i = 0; i < N; i++) begin
        d = m_bright[i] / (1 << DSH);
        if (d == 0 && m_bright[i] > 0) d = 1;
        nb[i] = (i == h) ? MAXB : m_bright[i] - d;
      end
      for (int i = 0; i < N; i++) m_bright[i] = nb[i];
      s = int'(step);
      if (mode) begin
        m_dir = 0;
        n = m_pos + s;
        if (n >= PSPAN) begin m_pos = n - PSPAN; m_es = 1; end
        else m_pos = n;
      end else if (m_dir == 0) begin
        if (m_pos + s >= PMAX) begin m_pos = PMAX; m_dir = 1; m_es = 1; end
        else m_pos = m_pos + s;
      end else begin
        if (m_pos <= s) begin m_pos = 0; m_dir = 0; m_es = 1; end
        else m_pos = m_pos - s;
      end
    end
    if (enable) m_cnt = (tick != 0) ? 0 : m_cnt + 1;
    m_pwm = (m_pwm + 1) % (MAXB + 1);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      model_step();
      #1;
      chk("led", 32'(led), 32'(m_led));
      chk("head", 32'(head), 32'(m_pos / (1 << FRAC)));
      chk("end_stop", 32'(end_stop), 32'(m_es));
      es_count += int'(end_stop);
    end
  endtask

  // Cycles from reset release until head first leaves 0; bounded at 20.
  task automatic first_move(input string tag);
    int first;
    first = 0;
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      run(1);
      if (first == 0 && head != 3'd0) first = c;
    end
    chk(tag, 32'(first), 32'(PRE));
  endtask

  initial begin
    int hsave, on_head, on_other, other;
    model_reset();

    // power-on reset, then bounce sweep with step 4
    run(3);
    first_move("first_tick_after_reset");
    es_count = 0;
    run(14 * PRE * 2);
    chk("bounce_end_stops_2_periods", 32'(es_count), 32'd4);
    run(2 * PRE + 2);

    // asynchronous reset mid-sweep
    #3 rst = 1'b1;
    #1;
    chk("async_rst_head", 32'(head), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_end_stop", 32'(end_stop), 32'd0);
    model_reset();
    run(2);
    first_move("first_tick_after_midsweep_reset");

    // wrap mode with fractional step
    mode = 1'b1; step = 5'd3;
    es_count = 0;
    run(32 * PRE);
    chk("wrap_end_stops_32_ticks", 32'(es_count), 32'd3);

    // frozen head: tail decays, then check PWM duty on head and tail LED
    step = 5'd0;
    run(40 * PRE);
    hsave = int'(head);
    other = (hsave + 1) % N;
    on_head = 0; on_other = 0;
    for (int c = 0; c <= MAXB; c++) begin
      run(1);
      on_head  += int'(led[hsave]);
      on_other += int'(led[other]);
    end
    chk("duty_max_bright", 32'(on_head), 32'(MAXB));
    chk("duty_zero_bright", 32'(on_other), 32'd0);

    // enable freeze and resume
    step = 5'd4; mode = 1'b0;
    run(5 * PRE + 1);
    hsave = int'(head);
    enable = 1'b0;
    es_count = 0;
    run(1);
    chk("freeze_led_off", 32'(led), 32'd0);
    run(3 * PRE - 1);
    chk("freeze_head_held", 32'(head), 32'(hsave));
    chk("freeze_no_end_stop", 32'(es_count), 32'd0);
    enable = 1'b1;
    run(4 * PRE);

    // randomized stimulus
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 1'b0;
      if ($urandom_range(15) == 0) begin
        enable = ($urandom_range(7) != 0);
        mode   = 1'($urandom_range(1));
        step   = SW'($urandom_range(PSPAN - 1));
      end
      if ($urandom_range(299) == 0) rst = 1'b1;
      run(1);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
# led_scanner

Parametrised LED scanner driving a bank of PWM-dimmed LEDs with a moving head and a decaying tail. It supports bounce and wrap-around chase modes, fractional-speed motion and a runtime speed input. It sits between the board clock and the user LED bank as the general-purpose successor of the fixed 8-LED sweep. It exposes head position and an end-of-sweep pulse so other blocks, such as RGB colour sequencing, can synchronise to the pattern.

## Interface
- NUM_LEDS, 8: number of LED channels, ≥2
- PWM_BITS, 10: PWM/brightness resolution; MAX = 2^PWM_BITS−1
- FRAC_BITS, 8: fractional position bits (sub-LED motion resolution)
- STEP_W, 8: width of step input, ≤ IDX_W+FRAC_BITS
- PRESCALE, 65536: clock cycles per motion tick, ≥2
- DECAY_SHIFT, 2: tail decay per tick is b>>DECAY_SHIFT
- Derived: IDX_W = max(1, clog2(NUM_LEDS)); POS_MAX = (NUM_LEDS−1)<<FRAC_BITS; POS_SPAN = NUM_LEDS<<FRAC_BITS
- Clocking and reset: one clock; reset is asynchronous and active-high
- clk_16mhz  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = run; 0 = freeze motion, blank LEDs
- mode  in  1  0 = bounce, 1 = wrap (chase)
- step  in  STEP_W  position increment per tick, in 1/2^FRAC_BITS LED units; 0 = frozen head
- led  out  NUM_LEDS  registered PWM outputs
- head  out  IDX_W  current head index = pos[IDX_W+FRAC_BITS−1:FRAC_BITS]
- end_stop  out  1  one-cycle pulse on reversal or wrap

## Operation
- **Prescaler**
  - Counter runs 0..PRESCALE−1 while enable=1 and holds while enable=0.
  - tick = 1 for one cycle when the counter equals PRESCALE−1; the counter then returns to 0.
- **Position state**
  - pos is IDX_W+FRAC_BITS bits; dir is 0 for up, 1 for down.
  - All comparisons are done at IDX_W+FRAC_BITS+1 bits, so there is no overflow.
- **Bounce mode (mode=0), on tick**
  - dir=0: if pos+step ≥ POS_MAX, then pos←POS_MAX, dir←1, end_stop. Otherwise pos←pos+step.
  - dir=1: if pos ≤ step, then pos←0, dir←0, end_stop. Otherwise pos←pos−step.
- **Wrap mode (mode=1), on tick**
  - dir is forced to 0.
  - n = pos+step; if n ≥ POS_SPAN, then pos←n−POS_SPAN and end_stop; otherwise pos←n.
  - The driver keeps step < POS_SPAN.
- **Mode switching**
  - mode is sampled only on tick.
  - Switching to bounce continues from the current pos with dir=0.
- **Brightness, per channel i, on tick**
  - bright[i]←MAX if i == head (the pre-update head); otherwise it decays.
  - Decay: d = b>>DECAY_SHIFT; if d == 0 and b ≠ 0, then d = 1. b←b−d, saturating at 0.
  - head ≥ NUM_LEDS cannot occur.
- **PWM**
  - pwm_ctr is PWM_BITS wide, free-running every cycle, and wraps MAX→0.
  - led[i]←enable && (pwm_ctr < bright[i]), registered.
  - Duty is therefore bright/2^PWM_BITS; MAX gives 1023/1024 at PWM_BITS=10.
- **enable=0**
  - Holds prescaler, pos, dir and bright; led forced to 0 on the next cycle; end_stop held 0.
  - pwm_ctr keeps running.
- **step=0**
  - Ticks still occur and pos is unchanged.
  - The head stays at MAX and the rest of the tail decays to 0.

## Timing
- **Reset values (asynchronous)**
  - pos=0, dir=0, prescaler=0, pwm_ctr=0, all bright=0.
  - led=0, head=0, end_stop=0.
- Reset mid-sweep returns every register to these values immediately. The first tick after release occurs PRESCALE cycles later.
- **Tick cycle updates**
  - pos, dir and bright update on the clock edge that ends the tick cycle.
  - head reflects the new pos on that same edge.
  - end_stop is high for exactly the cycle following that edge.
- The brightness maximum lags the head output by one tick.
- led lags bright and pwm_ctr by one cycle.
- Simultaneous reversal and mode change: the old mode is applied on that tick, and the new mode applies from the next tick.

## Test plan
- **Reset:** assert rst mid-sweep with enable=1 → all outputs 0 asynchronously; after release, first head change after exactly PRESCALE cycles.
- **Bounce sweep:** NUM_LEDS=8, FRAC_BITS=2, PRESCALE=4, step=4, mode=0 → head 0,1,…,7,6,…,0; end_stop pulses at the ticks reaching pos 28 and pos 0; period 14 ticks.
- **Wrap and fractional step:** mode=1, step=3, FRAC_BITS=2 → pos 0,3,6,…,30,1 (33−32); end_stop on the 1 transition; head advances ≈0.75 LED per tick.
- **Tail decay:** PWM_BITS=10, DECAY_SHIFT=2, step=0 then moved → former head brightness 1023→768→576→432; small values decay by 1 until 0.
- **PWM duty:** force bright=256 → led high exactly 256 of every 1024 cycles; bright=0 → never high; bright=MAX → low 1 of 1024.
- **Enable freeze:** enable=0 for 3·PRESCALE cycles → led=0 the next cycle, head and pos unchanged; re-enable resumes from the held prescaler count with no extra end_stop.
